// File: rtl/fpga_panel_io_pkg.sv
// Shared key indices and window-count helper for the front-panel controller.
package panel_pkg;

   localparam int KEY_LOAD = 0;
   localparam int KEY_STEP = 1;
   localparam int KEY_PAGE = 2;
   localparam int NUM_KEYS = 3;

   // Number of display windows needed to cover the whole data word.
   function automatic int calc_pages(input int data_w, input int hex_digits);
      return (data_w + 4 * hex_digits - 1) / (4 * hex_digits);
   endfunction

endpackage

// File: rtl/fpga_panel_io_key_debounce.sv
// One push-button: two-flop synchroniser, stable-count debouncer and press event.
module key_debounce #(
   parameter int DEB_CYCLES = 50000
) (
   input  logic clk_i,
   input  logic rst_n_i,
   input  logic key_n_raw_i,
   output logic pressed_o,
   output logic press_evt_o
);

   localparam int CNT_W = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEB_CYCLES - 1);

   logic             s1_q, s2_q, state_q, evt_q;
   logic [CNT_W-1:0] cnt_q;

   always_ff @(posedge clk_i) begin
      if (!rst_n_i) begin
         s1_q    <= 1'b1;
         s2_q    <= 1'b1;
         state_q <= 1'b1;
         cnt_q   <= '0;
         evt_q   <= 1'b0;
      end else begin
         s1_q  <= key_n_raw_i;
         s2_q  <= s1_q;
         evt_q <= 1'b0;
         if (s2_q == state_q) begin
            cnt_q <= '0;
         end else if (cnt_q == CNT_MAX) begin
            state_q <= s2_q;
            cnt_q   <= '0;
            // Only a released->pressed transition (state was 1) is an event.
            evt_q   <= state_q;
         end else begin
            cnt_q <= cnt_q + CNT_W'(1);
         end
      end
   end

   assign pressed_o   = ~state_q;
   assign press_evt_o = evt_q;

endmodule

// File: rtl/fpga_panel_io.sv
// Board front panel: debounced keys, switch input latch, CPU single-step with
// optional auto-repeat, and a paged window of the CPU result for the hex digits.
module fpga_panel_io
   import panel_pkg::*;
#(
   parameter int DATA_W        = 16,
   parameter int SW_W          = 10,
   parameter int HEX_DIGITS    = 4,
   parameter int DEB_CYCLES    = 50000,
   parameter int REPEAT_CYCLES = 0,
   localparam int PAGES  = calc_pages(DATA_W, HEX_DIGITS),
   localparam int PAGE_W = (PAGES > 1) ? $clog2(PAGES) : 1
) (
   input  logic                    clk_i,
   input  logic                    rst_n_i,
   input  logic [2:0]              key_n_i,
   input  logic [SW_W-1:0]         sw_i,
   input  logic [DATA_W-1:0]       cpu_result_i,
   output logic [DATA_W-1:0]       cpu_input_o,
   output logic                    step_pulse_o,
   output logic [4*HEX_DIGITS-1:0] hex_nibbles_o,
   output logic [PAGE_W-1:0]       page_o,
   output logic [SW_W-1:0]         ledr_o
);

   localparam int WIN_W = 4 * HEX_DIGITS;
   localparam int EXT_W = PAGES * WIN_W;

   logic [NUM_KEYS-1:0] key_pressed, key_evt;
   logic                unused_pressed;
   logic                rep_fire;

   logic [SW_W-1:0]   sw_s1_q, sw_s2_q, ledr_q;
   logic [DATA_W-1:0] cpu_input_q, cpu_input_d;
   logic [PAGE_W-1:0] page_q, page_d;
   logic [WIN_W-1:0]  hex_q, hex_d;
   logic [EXT_W-1:0]  res_ext;

   for (genvar k = 0; k < NUM_KEYS; k++) begin : g_key
      key_debounce #(
         .DEB_CYCLES (DEB_CYCLES)
      ) u_deb (
         .clk_i       (clk_i),
         .rst_n_i     (rst_n_i),
         .key_n_raw_i (key_n_i[k]),
         .pressed_o   (key_pressed[k]),
         .press_evt_o (key_evt[k])
      );
   end

   assign unused_pressed = ^{key_pressed[KEY_LOAD], key_pressed[KEY_PAGE]};

   // Result padded with zeros so the last window may extend past DATA_W.
   assign res_ext = EXT_W'(cpu_result_i);

   always_comb begin
      cpu_input_d = cpu_input_q;
      if (key_evt[KEY_LOAD]) cpu_input_d = DATA_W'($signed(sw_s2_q));
      page_d = page_q;
      if (key_evt[KEY_PAGE])
         page_d = (page_q == PAGE_W'(PAGES - 1)) ? '0 : page_q + PAGE_W'(1);
      hex_d = WIN_W'(res_ext >> (int'(page_q) * WIN_W));
   end

   always_ff @(posedge clk_i) begin
      if (!rst_n_i) begin
         sw_s1_q     <= '0;
         sw_s2_q     <= '0;
         ledr_q      <= '0;
         cpu_input_q <= '0;
         page_q      <= '0;
         hex_q       <= '0;
      end else begin
         sw_s1_q     <= sw_i;
         sw_s2_q     <= sw_s1_q;
         ledr_q      <= sw_i;
         cpu_input_q <= cpu_input_d;
         page_q      <= page_d;
         hex_q       <= hex_d;
      end
   end

   if (REPEAT_CYCLES > 0) begin : g_repeat
      localparam int REP_W = (REPEAT_CYCLES > 1) ? $clog2(REPEAT_CYCLES) : 1;
      logic [REP_W-1:0] rep_cnt_q;
      logic             rep_q;

      // Counter sits at 0 in every pulse cycle, so pulses land REPEAT_CYCLES apart.
      always_ff @(posedge clk_i) begin
         if (!rst_n_i || !key_pressed[KEY_STEP]) begin
            rep_cnt_q <= '0;
            rep_q     <= 1'b0;
         end else if (rep_cnt_q == REP_W'(REPEAT_CYCLES - 1)) begin
            rep_cnt_q <= '0;
            rep_q     <= 1'b1;
         end else begin
            rep_cnt_q <= rep_cnt_q + REP_W'(1);
            rep_q     <= 1'b0;
         end
      end

      // Gating with the level kills a repeat that lands on the release edge.
      assign rep_fire = rep_q & key_pressed[KEY_STEP];
   end else begin : g_no_repeat
      assign rep_fire = 1'b0;
   end

   assign step_pulse_o  = key_evt[KEY_STEP] | rep_fire;
   assign cpu_input_o   = cpu_input_q;
   assign hex_nibbles_o = hex_q;
   assign page_o        = page_q;
   assign ledr_o        = ledr_q;

endmodule

// File: tb/tb_fpga_panel_io.sv
// Directed bench: a 16-bit no-repeat instance and a 32-bit auto-repeat instance share the inputs.
module tb_fpga_panel_io;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [2:0]  key_n = 3'b111;
   logic [9:0]  sw = '0;
   logic [31:0] res_b = '0;

   logic [15:0] a_cpu_input, a_hex;
   logic        a_step;
   logic [0:0]  a_page;
   logic [9:0]  a_ledr;

   logic [31:0] b_cpu_input;
   logic [15:0] b_hex;
   logic        b_step;
   logic [0:0]  b_page;
   logic [9:0]  b_ledr;

   int tests_run = 0;
   int tests_failed = 0;

   always #5 clk = ~clk;

   fpga_panel_io #(
      .DATA_W(16), .SW_W(10), .HEX_DIGITS(4), .DEB_CYCLES(4), .REPEAT_CYCLES(0)
   ) dut_a (
      .clk_i         (clk),
      .rst_n_i       (rst_n),
      .key_n_i       (key_n),
      .sw_i          (sw),
      .cpu_result_i  (res_b[15:0]),
      .cpu_input_o   (a_cpu_input),
      .step_pulse_o  (a_step),
      .hex_nibbles_o (a_hex),
      .page_o        (a_page),
      .ledr_o        (a_ledr)
   );

   fpga_panel_io #(
      .DATA_W(32), .SW_W(10), .HEX_DIGITS(4), .DEB_CYCLES(4), .REPEAT_CYCLES(8)
   ) dut_b (
      .clk_i         (clk),
      .rst_n_i       (rst_n),
      .key_n_i       (key_n),
      .sw_i          (sw),
      .cpu_result_i  (res_b),
      .cpu_input_o   (b_cpu_input),
      .step_pulse_o  (b_step),
      .hex_nibbles_o (b_hex),
      .page_o        (b_page),
      .ledr_o        (b_ledr)
   );

   task automatic apply_reset;
      @(negedge clk);
      rst_n = 1'b0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic test_reset;
      int first_a, first_b;
      key_n = 3'b000; sw = 10'h3FF; res_b = 32'hDEADBEEF;
      @(negedge clk);
      rst_n = 1'b0;
      repeat (2) @(negedge clk);
      tests_run++;
      if (a_cpu_input !== 16'h0 || b_cpu_input !== 32'h0) begin
         tests_failed++;
         $display("FAIL reset_cpu_input: got %h/%h expected 0", a_cpu_input, b_cpu_input);
      end
      tests_run++;
      if (a_page !== 1'b0 || b_page !== 1'b0) begin
         tests_failed++;
         $display("FAIL reset_page: got %h/%h expected 0", a_page, b_page);
      end
      tests_run++;
      if (a_step !== 1'b0 || b_step !== 1'b0) begin
         tests_failed++;
         $display("FAIL reset_step: got %b/%b expected 0", a_step, b_step);
      end
      tests_run++;
      if (a_hex !== 16'h0 || b_hex !== 16'h0 || a_ledr !== 10'h0) begin
         tests_failed++;
         $display("FAIL reset_hex_ledr: got %h/%h/%h expected 0", a_hex, b_hex, a_ledr);
      end
      rst_n = 1'b1;
      first_a = 0; first_b = 0;
      for (int i = 1; i <= 10; i++) begin
         @(negedge clk);
         if (first_a == 0 && a_step === 1'b1) first_a = i;
         if (first_b == 0 && b_step === 1'b1) first_b = i;
      end
      tests_run++;
      if (first_a != 6 || first_b != 6) begin
         tests_failed++;
         $display("FAIL reset_first_step: got cycle %0d/%0d expected 6", first_a, first_b);
      end
   endtask

   task automatic test_bounce;
      int bounce_pulses, pulses, pos;
      key_n = 3'b111; sw = '0;
      apply_reset();
      bounce_pulses = 0;
      for (int r = 0; r < 5; r++) begin
         for (int c = 0; c < 4; c++) begin
            key_n[1] = (c == 3);
            @(negedge clk);
            if (a_step === 1'b1 || b_step === 1'b1) bounce_pulses++;
         end
      end
      tests_run++;
      if (bounce_pulses != 0) begin
         tests_failed++;
         $display("FAIL bounce_no_pulse: got %0d pulses expected 0", bounce_pulses);
      end
      key_n = 3'b101;
      pulses = 0; pos = 0;
      for (int i = 1; i <= 12; i++) begin
         @(negedge clk);
         if (a_step === 1'b1) begin
            pulses++;
            pos = i;
         end
      end
      tests_run++;
      if (pulses != 1 || pos != 6) begin
         tests_failed++;
         $display("FAIL bounce_single_pulse: got %0d pulses last at %0d expected 1 at 6", pulses, pos);
      end
      key_n = 3'b111;
      repeat (10) @(negedge clk);
   endtask

   task automatic test_load;
      key_n = 3'b111; sw = 10'h2A5;
      apply_reset();
      key_n = 3'b110;
      repeat (9) @(negedge clk);
      tests_run++;
      if (a_cpu_input !== 16'hFEA5) begin
         tests_failed++;
         $display("FAIL load_neg16: got %h expected FEA5", a_cpu_input);
      end
      tests_run++;
      if (b_cpu_input !== 32'hFFFFFEA5) begin
         tests_failed++;
         $display("FAIL load_neg32: got %h expected FFFFFEA5", b_cpu_input);
      end
      tests_run++;
      if (a_ledr !== 10'h2A5 || b_page !== 1'b0) begin
         tests_failed++;
         $display("FAIL load_ledr_page: got %h/%h expected 2A5/0", a_ledr, b_page);
      end
      key_n = 3'b111;
      repeat (10) @(negedge clk);
      sw = 10'h0F0;
      repeat (3) @(negedge clk);
      key_n = 3'b110;
      repeat (9) @(negedge clk);
      tests_run++;
      if (a_cpu_input !== 16'h00F0 || b_cpu_input !== 32'h000000F0) begin
         tests_failed++;
         $display("FAIL load_pos: got %h/%h expected 00F0/000000F0", a_cpu_input, b_cpu_input);
      end
      tests_run++;
      if (a_ledr !== 10'h0F0) begin
         tests_failed++;
         $display("FAIL ledr_copy: got %h expected 0F0", a_ledr);
      end
      key_n = 3'b111;
      repeat (10) @(negedge clk);
   endtask

   task automatic test_paging;
      key_n = 3'b111; res_b = 32'hDEADBEEF;
      apply_reset();
      @(negedge clk);
      tests_run++;
      if (b_hex !== 16'hBEEF || b_page !== 1'b0 || a_hex !== 16'hBEEF) begin
         tests_failed++;
         $display("FAIL page_initial: got %h/%h/%h expected BEEF/0/BEEF", b_hex, b_page, a_hex);
      end
      key_n = 3'b011;
      repeat (9) @(negedge clk);
      tests_run++;
      if (b_hex !== 16'hDEAD || b_page !== 1'b1) begin
         tests_failed++;
         $display("FAIL page_next: got %h/%h expected DEAD/1", b_hex, b_page);
      end
      tests_run++;
      if (a_page !== 1'b0 || a_hex !== 16'hBEEF) begin
         tests_failed++;
         $display("FAIL page_single: got %h/%h expected 0/BEEF", a_page, a_hex);
      end
      key_n = 3'b111;
      repeat (10) @(negedge clk);
      key_n = 3'b011;
      repeat (9) @(negedge clk);
      tests_run++;
      if (b_hex !== 16'hBEEF || b_page !== 1'b0) begin
         tests_failed++;
         $display("FAIL page_wrap: got %h/%h expected BEEF/0", b_hex, b_page);
      end
      key_n = 3'b111;
      repeat (10) @(negedge clk);
   endtask

   task automatic test_auto_repeat;
      bit found;
      bit exp_a, exp_b;
      key_n = 3'b111;
      apply_reset();
      key_n = 3'b101;
      found = 1'b0;
      for (int i = 1; i <= 20; i++) begin
         @(negedge clk);
         if (b_step === 1'b1) begin
            found = 1'b1;
            break;
         end
      end
      tests_run++;
      if (!found) begin
         tests_failed++;
         $display("FAIL repeat_first_pulse: got none expected pulse within 20 cycles");
      end else begin
         for (int j = 0; j <= 60; j++) begin
            if (j > 0) @(negedge clk);
            exp_b = (j <= 40) && (j % 8 == 0);
            exp_a = (j == 0);
            tests_run++;
            if (b_step !== exp_b || a_step !== exp_a) begin
               tests_failed++;
               $display("FAIL repeat_cycle_%0d: got %b/%b expected %b/%b", j, b_step, a_step, exp_b, exp_a);
            end
            if (j == 36) key_n = 3'b111;
         end
      end
      key_n = 3'b111;
      repeat (5) @(negedge clk);
   endtask

   task automatic test_reset_midop;
      logic [15:0] exp;
      key_n = 3'b111; sw = 10'h255;
      apply_reset();
      key_n = 3'b110;
      repeat (4) @(negedge clk);
      rst_n = 1'b0;
      @(negedge clk);
      tests_run++;
      if (a_cpu_input !== 16'h0 || a_step !== 1'b0) begin
         tests_failed++;
         $display("FAIL midop_in_reset: got %h/%b expected 0/0", a_cpu_input, a_step);
      end
      rst_n = 1'b1;
      for (int i = 1; i <= 9; i++) begin
         @(negedge clk);
         exp = (i >= 7) ? 16'hFE55 : 16'h0000;
         tests_run++;
         if (a_cpu_input !== exp) begin
            tests_failed++;
            $display("FAIL midop_cycle_%0d: got %h expected %h", i, a_cpu_input, exp);
         end
      end
      key_n = 3'b111;
      repeat (10) @(negedge clk);
   endtask

   initial begin
      test_reset();
      test_bounce();
      test_load();
      test_paging();
      test_auto_repeat();
      test_reset_midop();
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
